hier_leaf_fifo: RTL

Leaf buffering stage for the generated instance hierarchy: a first-word-fall-through FIFO with valid/ready handshakes on both sides, an occupancy counter, a three-state fill tracker and a running XOR checksum of accepted words. It is the block instantiated at the bottom of each generated branch, giving leaves real sequential behaviour. Upstream it accepts words from the leaf's producer. Downstream it presents them, in order, to the leaf's consumer.

---
 rtl/hier_leaf_pkg.sv | 26 ++
 rtl/hier_leaf_ptr.sv | 43 ++++
 rtl/hier_leaf_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/hier_leaf_pkg.sv
// ============================================================================
// Module   : hier_leaf_pkg
// Brief    : Shared types, defaults and sizing helper for the leaf FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hier_leaf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fill_state_e;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 4;

    // Occupancy needs one extra bit so that DEPTH itself is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hier_leaf_ptr.sv
// ============================================================================
// Module   : hier_leaf_ptr
// Brief    : Wrapping pointer register with synchronous clear and increment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hier_leaf_ptr #(
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Clear wins over increment; the pointer wraps by plain overflow.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/hier_leaf_fifo.sv
// ============================================================================
// Module   : hier_leaf_fifo
// Brief    : First-word-fall-through leaf FIFO with occupancy, fill state and
//            running XOR checksum of accepted words.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hier_leaf_fifo
    import hier_leaf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic [1:0]                state,
    output logic [DATA_W-1:0]         checksum
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] checksum_q;
    logic [DATA_W-1:0] checksum_d;
    fill_state_e       state_q;
    fill_state_e       state_d;

    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Handshakes depend on fill state only, so no input reaches an output.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    hier_leaf_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    hier_leaf_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    always_comb begin
        mem_d      = mem_q;
        checksum_d = checksum_q;
        count_d    = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (push) begin
                mem_d[wr_ptr] = in_data;
                checksum_d    = checksum_q ^ in_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = PARTIAL;
            PARTIAL: begin
                if (count_d == '0) begin
                    state_d = EMPTY;
                end else if (count_d == C_FULL_CNT) begin
                    state_d = FULL;
                end
            end
            FULL:    if (pop) state_d = PARTIAL;
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '{default: '0};
            count_q    <= '0;
            checksum_q <= '0;
            state_q    <= EMPTY;
        end else begin
            mem_q      <= mem_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            state_q    <= state_d;
        end
    end

    assign out_data = mem_q[rd_ptr];
    assign count    = count_q;
    assign state    = state_q;
    assign checksum = checksum_q;

endmodule

`default_nettype wire
